// File: rtl/mem_port_arbiter_if.sv
// Core-side fetch and load/store handshakes plus the shared memory bus,
// bundled so the arbiter and its environment connect through one port.
interface mem_port_arbiter_if;
  // Instruction-fetch port
  logic        inst_ena;
  logic [63:0] inst_addr;
  logic [31:0] inst;
  logic        bui_inst_valid;
  logic        inst_ready;
  // Load/store port
  logic [63:0] data_addr;
  logic        we;
  logic        re;
  logic [7:0]  wmask;
  logic [63:0] data_o;
  logic [63:0] data_i;
  logic        mem_finish;
  // Shared memory bus
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [7:0]  bus_wmask;
  logic [63:0] bus_wdata;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;

  // Arbiter side
  modport slave (
    input  inst_ena, inst_addr, inst_ready,
    input  data_addr, we, re, wmask, data_o,
    input  bus_ready, bus_rvalid, bus_rdata,
    output inst, bui_inst_valid, data_i, mem_finish,
    output bus_valid, bus_we, bus_addr, bus_wmask, bus_wdata
  );

  // Core plus memory side
  modport master (
    output inst_ena, inst_addr, inst_ready,
    output data_addr, we, re, wmask, data_o,
    output bus_ready, bus_rvalid, bus_rdata,
    input  inst, bui_inst_valid, data_i, mem_finish,
    input  bus_valid, bus_we, bus_addr, bus_wmask, bus_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch port and the load/store port onto one single-outstanding
// memory bus. Loads/stores win by default; a starvation counter forces a fetch
// after STARVE_LIMIT consecutive data grants. Fetch responses made stale by a
// redirect are dropped. Every output is driven straight from a register.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave port
);

  typedef enum logic [2:0] {
    IDLE,
    IF_REQ,
    IF_RESP,
    IF_HOLD,
    LS_REQ,
    LS_RESP,
    LS_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic              grant_ls, grant_if;
  logic              redirect;

  logic [63:0]       lat_addr_q;   // address presented on the bus
  logic [63:0]       lat_pc_q;     // unaligned fetch PC, for half-select and redirect compare
  logic              lat_we_q;
  logic [7:0]        lat_wmask_q;
  logic [63:0]       lat_wdata_q;

  logic [CNT_W-1:0]  starve_cnt_q;
  logic              stale_q;

  logic              bus_valid_q;
  logic              mem_finish_q;
  logic              bui_inst_valid_q;
  logic [63:0]       data_i_q;
  logic [31:0]       inst_q;

  // The in-flight fetch no longer matches what the core wants.
  assign redirect = !port.inst_ena || (port.inst_addr != lat_pc_q);

  // Next-state logic: grant in IDLE, then walk the single bus transaction.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    grant_ls = 1'b0;
    grant_if = 1'b0;
    case (state_q)
      IDLE: begin
        if ((port.re || port.we) && (starve_cnt_q < LIMIT)) begin
          grant_ls = 1'b1;
          state_d  = LS_REQ;
        end else if (port.inst_ena) begin
          grant_if = 1'b1;
          state_d  = IF_REQ;
        end
      end
      IF_REQ:  if (port.bus_ready) state_d = IF_RESP;
      IF_RESP: if (port.bus_rvalid) state_d = (stale_q || redirect) ? IDLE : IF_HOLD;
      IF_HOLD: if (redirect || port.inst_ready) state_d = IDLE;
      LS_REQ:  if (port.bus_ready) state_d = LS_RESP;
      LS_RESP: if (port.bus_rvalid) state_d = LS_DONE;
      LS_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and the handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q          <= IDLE;
      bus_valid_q      <= 1'b0;
      mem_finish_q     <= 1'b0;
      bui_inst_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      bus_valid_q      <= (state_d == IF_REQ) || (state_d == LS_REQ);
      mem_finish_q     <= (state_d == LS_DONE);
      bui_inst_valid_q <= (state_d == IF_HOLD);
    end
  end

  // Request latch: the bus sees only these, captured at grant time.
  always_ff @(posedge clk) begin
    // NOTE: the datapath latches are reset too, because the bus outputs they
    // drive must read zero straight out of reset.
    if (rst) begin
      lat_addr_q  <= '0;
      lat_pc_q    <= '0;
      lat_we_q    <= 1'b0;
      lat_wmask_q <= '0;
      lat_wdata_q <= '0;
    end else if (grant_ls) begin
      lat_addr_q  <= port.data_addr;
      lat_we_q    <= port.we;
      lat_wmask_q <= port.we ? port.wmask : 8'h00;
      lat_wdata_q <= port.we ? port.data_o : 64'd0;
    end else if (grant_if) begin
      lat_addr_q  <= {port.inst_addr[63:3], 3'b000};
      lat_pc_q    <= port.inst_addr;
      lat_we_q    <= 1'b0;
      lat_wmask_q <= 8'h00;
      lat_wdata_q <= 64'd0;
    end
  end

  // Starvation counter and stale-fetch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      stale_q      <= 1'b0;
    end else begin
      if (grant_if || ((state_q == IDLE) && !port.inst_ena))
        starve_cnt_q <= '0;
      else if (grant_ls && port.inst_ena && (starve_cnt_q < LIMIT))
        starve_cnt_q <= starve_cnt_q + CNT_W'(1);

      if (grant_ls || grant_if)
        stale_q <= 1'b0;
      else if (((state_q == IF_REQ) || (state_q == IF_RESP)) && redirect)
        stale_q <= 1'b1;
    end
  end

  // Response capture: load data (zero for store acks) and the selected fetch half.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_i_q <= '0;
      inst_q   <= '0;
    end else begin
      if ((state_q == LS_RESP) && port.bus_rvalid)
        data_i_q <= lat_we_q ? 64'd0 : port.bus_rdata;
      if ((state_q == IF_RESP) && port.bus_rvalid && (state_d == IF_HOLD))
        inst_q <= lat_pc_q[2] ? port.bus_rdata[63:32] : port.bus_rdata[31:0];
    end
  end

  assign port.bus_valid      = bus_valid_q;
  assign port.bus_we         = lat_we_q;
  assign port.bus_addr       = lat_addr_q;
  assign port.bus_wmask      = lat_wmask_q;
  assign port.bus_wdata      = lat_wdata_q;
  assign port.mem_finish     = mem_finish_q;
  assign port.data_i         = data_i_q;
  assign port.bui_inst_valid = bui_inst_valid_q;
  assign port.inst           = inst_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter. Expected bus requests
// and responses are derived from each transaction's parameters.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus_if ();

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.inst_ena   = 1'b0;
    bus_if.inst_addr  = '0;
    bus_if.inst_ready = 1'b0;
    bus_if.data_addr  = '0;
    bus_if.we         = 1'b0;
    bus_if.re         = 1'b0;
    bus_if.wmask      = '0;
    bus_if.data_o     = '0;
    bus_if.bus_ready  = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus_valid"},  bus_if.bus_valid, 0);
    check({tag, "_bus_we"},     bus_if.bus_we, 0);
    check({tag, "_bus_addr"},   bus_if.bus_addr, 0);
    check({tag, "_bus_wmask"},  bus_if.bus_wmask, 0);
    check({tag, "_bus_wdata"},  bus_if.bus_wdata, 0);
    check({tag, "_inst_valid"}, bus_if.bui_inst_valid, 0);
    check({tag, "_inst"},       bus_if.inst, 0);
    check({tag, "_mem_finish"}, bus_if.mem_finish, 0);
    check({tag, "_data_i"},     bus_if.data_i, 0);
  endtask

  // One load or store from IDLE; core holds the request through completion.
  task automatic run_ls(input logic is_store, input logic [63:0] addr, input logic [7:0] mask,
                        input logic [63:0] wdata, input int rdy_dly, input int rv_dly,
                        input logic [63:0] rdata);
    bus_if.we        = is_store;
    bus_if.re        = !is_store;
    bus_if.data_addr = addr;
    bus_if.wmask     = mask;
    bus_if.data_o    = wdata;
    tick();
    for (int d = 0; d <= rdy_dly; d++) begin
      check("ls_bus_valid", bus_if.bus_valid, 1);
      check("ls_bus_addr",  bus_if.bus_addr, addr);
      check("ls_bus_we",    bus_if.bus_we, is_store);
      check("ls_bus_wmask", bus_if.bus_wmask, is_store ? mask : 8'h00);
      if (is_store) check("ls_bus_wdata", bus_if.bus_wdata, wdata);
      bus_if.bus_ready = (d == rdy_dly);
      tick();
    end
    bus_if.bus_ready = 1'b0;
    check("ls_single_accept", bus_if.bus_valid, 0);
    for (int d = 0; d < rv_dly; d++) begin
      check("ls_early_finish", bus_if.mem_finish, 0);
      tick();
    end
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = rdata;
    tick();
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = {$urandom(), $urandom()};
    check("ls_finish", bus_if.mem_finish, 1);
    check("ls_data_i", bus_if.data_i, is_store ? 64'd0 : rdata);
    tick();
    check("ls_finish_pulse", bus_if.mem_finish, 0);
    check("ls_no_dup_req", bus_if.bus_valid, 0);
    bus_if.we = 1'b0;
    bus_if.re = 1'b0;
    tick();
    check("ls_idle", bus_if.bus_valid, 0);
  endtask

  // One fetch from IDLE; the core stalls acceptance for 'hold' cycles.
  task automatic run_if(input logic [63:0] addr, input int rdy_dly, input int rv_dly,
                        input logic [63:0] rdata, input int hold);
    logic [31:0] exp_inst;
    exp_inst = addr[2] ? rdata[63:32] : rdata[31:0];
    bus_if.inst_ena  = 1'b1;
    bus_if.inst_addr = addr;
    tick();
    for (int d = 0; d <= rdy_dly; d++) begin
      check("if_bus_valid", bus_if.bus_valid, 1);
      check("if_bus_addr",  bus_if.bus_addr, {addr[63:3], 3'b000});
      check("if_bus_we",    bus_if.bus_we, 0);
      check("if_bus_wmask", bus_if.bus_wmask, 0);
      bus_if.bus_ready = (d == rdy_dly);
      tick();
    end
    bus_if.bus_ready = 1'b0;
    check("if_single_accept", bus_if.bus_valid, 0);
    for (int d = 0; d < rv_dly; d++) begin
      check("if_early_valid", bus_if.bui_inst_valid, 0);
      tick();
    end
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = rdata;
    tick();
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = {$urandom(), $urandom()};
    for (int h = 0; h <= hold; h++) begin
      check("if_inst_valid", bus_if.bui_inst_valid, 1);
      check("if_inst", bus_if.inst, exp_inst);
      bus_if.inst_ready = (h == hold);
      tick();
    end
    bus_if.inst_ready = 1'b0;
    check("if_valid_drop", bus_if.bui_inst_valid, 0);
    check("if_no_dup_req", bus_if.bus_valid, 0);
    bus_if.inst_ena = 1'b0;
    tick();
    check("if_idle", bus_if.bus_valid, 0);
  endtask

  initial begin
    logic [63:0] fetch_a;
    logic [63:0] load_d;
    int          waited;

    // Reset values
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("post_reset_idle", bus_if.bus_valid, 0);

    // Load alone, minimum latency
    run_ls(1'b0, 64'h0000_0000_8000_0010, 8'h00, 64'd0, 0, 0, 64'h1122_3344_5566_7788);

    // Store held through 3 cycles of bus_ready=0
    run_ls(1'b1, 64'h0000_0000_8000_0020, 8'h0F, 64'h0000_0000_DEAD_BEEF, 3, 0, 64'hFFFF_FFFF_FFFF_FFFF);

    // Fetch upper half, inst_ready stalled 2 cycles
    run_if(64'h0000_0000_8000_0004, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 2);
    // Fetch lower half
    run_if(64'h0000_0000_8000_0008, 1, 1, 64'h0123_4567_89AB_CDEF, 0);

    // Contention: both requesters held; expect LS x4 then IF, repeating
    fetch_a = 64'h0000_0000_8000_3000;
    load_d  = 64'h0000_0000_8000_2000;
    bus_if.inst_ena   = 1'b1;
    bus_if.inst_addr  = fetch_a;
    bus_if.inst_ready = 1'b1;
    bus_if.re         = 1'b1;
    bus_if.data_addr  = load_d;
    for (int k = 0; k < 10; k++) begin
      waited = 0;
      while (!bus_if.bus_valid && waited < 20) begin
        tick();
        waited++;
      end
      check("grant_seen", bus_if.bus_valid, 1);
      check("grant_order", bus_if.bus_addr, ((k % 5) == 4) ? fetch_a : load_d);
      bus_if.bus_ready = 1'b1;
      tick();
      bus_if.bus_ready  = 1'b0;
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = {$urandom(), $urandom()};
      tick();
      bus_if.bus_rvalid = 1'b0;
    end
    bus_if.inst_ena   = 1'b0;
    bus_if.inst_ready = 1'b0;
    bus_if.re         = 1'b0;
    tick();
    tick();
    check("contention_quiet", bus_if.bus_valid, 0);

    // Redirect during IF_RESP drops the response and refetches
    bus_if.inst_ena  = 1'b1;
    bus_if.inst_addr = 64'h0000_0000_8000_0000;
    tick();
    check("redir_req", bus_if.bus_addr, 64'h0000_0000_8000_0000);
    bus_if.bus_ready = 1'b1;
    tick();
    bus_if.bus_ready = 1'b0;
    bus_if.inst_addr = 64'h0000_0000_8000_0100;
    tick();
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 64'h5555_5555_6666_6666;
    tick();
    bus_if.bus_rvalid = 1'b0;
    check("redir_dropped", bus_if.bui_inst_valid, 0);
    check("redir_idle", bus_if.bus_valid, 0);
    run_if(64'h0000_0000_8000_0100, 0, 0, 64'h7777_7777_8888_8888, 0);

    // Randomized single transactions with random bus latencies
    for (int n = 0; n < 30; n++) begin
      int          kind;
      logic [63:0] addr;
      logic [63:0] rdata;
      logic [63:0] wdata;
      logic [7:0]  mask;
      kind  = $urandom_range(0, 2);
      addr  = {$urandom(), $urandom()};
      rdata = {$urandom(), $urandom()};
      wdata = {$urandom(), $urandom()};
      mask  = 8'($urandom_range(0, 255));
      case (kind)
        0: run_ls(1'b0, addr, mask, wdata, $urandom_range(0, 3), $urandom_range(0, 3), rdata);
        1: run_ls(1'b1, addr, mask, wdata, $urandom_range(0, 3), $urandom_range(0, 3), rdata);
        default: run_if(addr, $urandom_range(0, 3), $urandom_range(0, 3), rdata, $urandom_range(0, 2));
      endcase
    end

    // Reset while a load waits for its response; late rvalid is ignored
    bus_if.re        = 1'b1;
    bus_if.data_addr = 64'h0000_0000_8000_0040;
    tick();
    bus_if.bus_ready = 1'b1;
    tick();
    bus_if.bus_ready = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    bus_if.re         = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    bus_if.bus_rvalid = 1'b0;
    check("stray_rvalid_finish", bus_if.mem_finish, 0);
    check("stray_rvalid_data", bus_if.data_i, 0);
    tick();
    check("stray_rvalid_finish2", bus_if.mem_finish, 0);
    check("stray_rvalid_bus", bus_if.bus_valid, 0);
    run_ls(1'b0, 64'h0000_0000_8000_0048, 8'h00, 64'd0, 0, 0, 64'hCAFE_F00D_1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's separate instruction-fetch port and load/store port onto one shared, single-outstanding memory bus. It sits between the core top (pc / if_id fetch handshake, mem-stage load/store) and the SoC memory interface. Loads/stores normally win; a starvation counter guarantees forward progress for fetch. It holds the core-side handshakes stable and drops fetch responses made stale by a redirect.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits before fetch is forced.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_ena  in  1  fetch request.
- inst_addr  in  64  fetch PC; bit 2 selects the 32-bit half of the 64-bit beat.
- inst  out  32  fetched instruction; valid while bui_inst_valid=1.
- bui_inst_valid  out  1  fetch response valid.
- inst_ready  in  1  core accepts the fetch response.
- data_addr  in  64  load/store address.
- we / re  in  1 / 1  store / load request; never both high.
- wmask  in  8  store byte enables.
- data_o  in  64  store data.
- data_i  out  64  load data; valid during mem_finish.
- mem_finish  out  1  one-cycle completion pulse for load or store.
- bus_valid  out  1  bus request.
- bus_ready  in  1  bus accepts the request.
- bus_we  out  1  write request.
- bus_addr  out  64  request address; fetch is forced 8-byte aligned (low 3 bits zero).
- bus_wmask  out  8  byte enables; 0x00 for reads.
- bus_wdata  out  64  write data.
- bus_rvalid  in  1  response (read data or write ack).
- bus_rdata  in  64  read data.

## Operation
- States: IDLE, IF_REQ, IF_RESP, IF_HOLD, LS_REQ, LS_RESP, LS_DONE.
- IDLE grant, evaluated each cycle:
  - (re|we) and starve_cnt<STARVE_LIMIT → LS_REQ.
  - else inst_ena → IF_REQ.
  - else stay.
- On grant the arbiter latches the address, mask, data and we. Bus outputs come only from these latches. In IF_REQ/LS_REQ they are held stable with bus_valid=1 until bus_ready=1, then the block moves to IF_RESP/LS_RESP with bus_valid=0.
- starve_cnt:
  - increments on each LS grant while inst_ena=1.
  - clears on any IF grant and whenever inst_ena=0 in IDLE.
  - saturates at STARVE_LIMIT.
- LS_RESP, on bus_rvalid: capture bus_rdata into data_i (zero for stores), go to LS_DONE.
- LS_DONE: mem_finish=1 for exactly this cycle. re/we are ignored this cycle because the core still holds the completed request. Next state IDLE.
- IF_RESP, on bus_rvalid:
  - stale=0: capture bus_rdata[63:32] if latched addr[2]=1, else [31:0]; go to IF_HOLD.
  - stale=1: discard the data, go to IDLE.
- stale flag: set in IF_REQ/IF_RESP when inst_ena=0 or inst_addr differs from the latched address. Cleared on grant.
- IF_HOLD:
  - bui_inst_valid=1 with inst stable until inst_ready=1; then IDLE.
  - If inst_addr changes or inst_ena drops while in IF_HOLD: go to IDLE, no valid delivered.
- Reset mid-transaction: state returns to IDLE regardless of any outstanding bus response. The bus side must also be reset; late bus_rvalid in IDLE is ignored.

## Timing
- Reset values: bus_valid=0, bus_we=0, bus_addr=0, bus_wmask=0, bus_wdata=0, bui_inst_valid=0, inst=0, mem_finish=0, data_i=0, starve_cnt=0, stale=0, state=IDLE.
- Request sampled in IDLE at cycle t → bus_valid=1 at t+1.
- bus_rvalid at cycle r → mem_finish or bui_inst_valid at r+1.
- Minimum load latency (bus_ready same cycle, rvalid next): request t0, bus_valid t1, rvalid t2, mem_finish t3. A fresh request is accepted at t4 at the earliest.
- Minimum fetch latency: inst_ena t0 → bui_inst_valid t3; with inst_ready=1 at t3, the next grant is at t4.
- Only one bus transaction is outstanding. bus_valid never asserts outside IF_REQ/LS_REQ.
- All outputs are registered; there is no combinational path from the core inputs to the bus outputs.

## Test plan
- Load alone: re=1, addr 0x8000_0010, bus_ready=1, rvalid one cycle later with rdata 0x1122334455667788 → bus_addr 0x8000_0010, bus_wmask 0x00, mem_finish pulse at t3 with data_i 0x1122334455667788, no duplicate bus request while re is still high at t3.
- Store: we=1, wmask 0x0F, data 0xDEADBEEF → bus_we=1, bus_wmask 0x0F, bus_wdata 0xDEADBEEF held through 3 cycles of bus_ready=0; exactly one bus acceptance; one mem_finish.
- Fetch half-select: inst_addr 0x8000_0004, rdata 0xAAAA_BBBB_CCCC_DDDD → bus_addr 0x8000_0000, inst 0xAAAABBBB. Hold inst_ready=0 for 2 cycles → bui_inst_valid stays 1 for 3 cycles.
- Contention and starvation: inst_ena and re both held continuously → 4 LS grants, then 1 IF grant, then LS resumes; starve_cnt clears after the IF grant.
- Redirect: change inst_addr 0x8000_0000→0x8000_0100 during IF_RESP → first response dropped (no bui_inst_valid), new fetch to 0x8000_0100 issued from IDLE.
- Reset mid-LS_RESP: assert rst for 1 cycle → all outputs at reset values on the next cycle; subsequent stray bus_rvalid produces no mem_finish.
